// File: rtl/line_playback_if.sv
// rtl/line_playback_if.sv - pixel write stream and playback handshake bundle for line_playback
interface line_playback_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  i_ena;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_wr_ready;
  logic                  o_overflow;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_last;

  modport master (
    output i_ena,
    output i_data,
    output i_ready,
    input  o_wr_ready,
    input  o_overflow,
    input  o_valid,
    input  o_data,
    input  o_last
  );

  modport slave (
    input  i_ena,
    input  i_data,
    input  i_ready,
    output o_wr_ready,
    output o_overflow,
    output o_valid,
    output o_data,
    output o_last
  );
endinterface

// File: rtl/line_playback.sv
// rtl/line_playback.sv - two-bank ping-pong line store with valid/ready playback
// Define LINE_PLAYBACK_REVERSE_EN to play each line back horizontally mirrored.
module line_playback #(
  parameter int DATA_WIDTH = 24,
  parameter int LINE_WIDTH = 1920
) (
  input logic           clk,
  input logic           rst,
  line_playback_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(LINE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LINE_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem0 [LINE_WIDTH];
  logic [DATA_WIDTH-1:0] mem1 [LINE_WIDTH];

  logic                  wbank;
  logic                  rbank;
  logic [ADDR_WIDTH-1:0] wcount;
  logic [ADDR_WIDTH-1:0] rcount;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [1:0]            full;
  logic [1:0]            full_next;

  logic                  wr_accept;
  logic                  wr_drop;
  logic                  wr_last;
  logic                  rd_advance;
  logic                  rd_last;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  valid_q;
  logic                  last_q;
  logic                  overflow_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign wr_accept  = bus.i_ena && !full[wbank];
  assign wr_drop    = bus.i_ena && full[wbank];
  assign wr_last    = wr_accept && (wcount == LAST_ADDR);
  assign rd_advance = full[rbank] && (!valid_q || bus.i_ready);
  assign rd_last    = rd_advance && (rcount == LAST_ADDR);

`ifdef LINE_PLAYBACK_REVERSE_EN
  assign raddr = LAST_ADDR - rcount;
`else
  assign raddr = rcount;
`endif

  assign rd_word = rbank ? mem1[raddr] : mem0[raddr];

  // Writer and reader both act on pre-edge flags; they never touch the same bank.
  always_comb begin
    full_next = full;
    if (wr_last) full_next[wbank] = 1'b1;
    if (rd_last) full_next[rbank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      if (wbank) mem1[wcount] <= bus.i_data;
      else       mem0[wcount] <= bus.i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      wcount     <= '0;
      rcount     <= '0;
      full       <= 2'b00;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
      data_q     <= '0;
    end else begin
      full       <= full_next;
      overflow_q <= wr_drop;

      if (wr_accept) begin
        if (wr_last) begin
          wcount <= '0;
          wbank  <= ~wbank;
        end else begin
          wcount <= wcount + ONE;
        end
      end

      // Output registers only move when the slot is empty or being consumed.
      if (rd_advance) begin
        data_q  <= rd_word;
        last_q  <= (rcount == LAST_ADDR);
        valid_q <= 1'b1;
        if (rd_last) begin
          rcount <= '0;
          rbank  <= ~rbank;
        end else begin
          rcount <= rcount + ONE;
        end
      end else if (bus.i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_wr_ready = !full[wbank];
  assign bus.o_overflow = overflow_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_data     = data_q;
  assign bus.o_last     = last_q;
endmodule
